// File: rtl/vga_pkg.sv
// Shared types and widths for the VGA line-buffer feeder.
package vga_pkg;

  localparam int BUF_ADDR_W = 11;
  localparam int PIX_W      = 10;
  localparam int LINE_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/vga_line_fetch.sv
// Fetches one scanline from framebuffer memory into the ping-pong line buffer.
// Define PIXEL_DOUBLE_EN to fetch half-width lines and write each pixel twice.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int unsigned       COLOR_DEPTH = 8,
  parameter int unsigned       H_PIXELS    = 640,
  parameter int unsigned       V_LINES     = 480,
  parameter int unsigned       ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] FB_BASE     = 'h001000
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   line_start,
  input  logic [LINE_W-1:0]      line_num,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [COLOR_DEPTH-1:0] mem_rdata,
  output logic [BUF_ADDR_W-1:0]  buf_addr,
  output logic [COLOR_DEPTH-1:0] buf_wdat,
  output logic                   buf_we,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

`ifdef PIXEL_DOUBLE_EN
  localparam int unsigned FETCH_N = H_PIXELS / 2;
`else
  localparam int unsigned FETCH_N = H_PIXELS;
`endif
  localparam logic [PIX_W-1:0] LAST_FETCH = PIX_W'(FETCH_N - 1);

  fetch_state_e           state_q;
  logic                   bank_q;
  logic [PIX_W-1:0]       pix_q;
  logic                   mem_req_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic                   busy_q;
  logic                   buf_we_q;
  logic [BUF_ADDR_W-1:0]  buf_addr_q;
  logic [COLOR_DEPTH-1:0] buf_wdat_q;
  logic                   done_q;
  logic                   overrun_q;
`ifdef PIXEL_DOUBLE_EN
  logic                   dbl_q;
`endif

  logic [ADDR_W-1:0] line_base;
  logic              trigger;

  // Constant-coefficient multiply; wraps at ADDR_W by design.
`ifdef PIXEL_DOUBLE_EN
  assign line_base = FB_BASE + ADDR_W'(line_num >> 1) * ADDR_W'(FETCH_N);
`else
  assign line_base = FB_BASE + ADDR_W'(line_num) * ADDR_W'(H_PIXELS);
`endif

  assign trigger = line_start && enable && (32'(line_num) < V_LINES);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; buf_we/done default low here so they only pulse.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bank_q     <= 1'b0;
      pix_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_wdat_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef PIXEL_DOUBLE_EN
      dbl_q      <= 1'b0;
`endif
    end else begin
      buf_we_q <= 1'b0;
      done_q   <= 1'b0;

      if (!enable)                  overrun_q <= 1'b0;
      else if (line_start && busy_q) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            bank_q     <= line_num[0];
            pix_q      <= '0;
            mem_addr_q <= line_base;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
`ifdef PIXEL_DOUBLE_EN
          // Second copy of the captured pixel; request resumes afterwards.
          if (dbl_q) begin
            buf_we_q      <= 1'b1;
            buf_addr_q[0] <= 1'b1;
            dbl_q         <= 1'b0;
            if (!enable) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              mem_req_q <= 1'b1;
            end
          end else
`endif
          if (mem_req_q && mem_ack) begin
            buf_we_q   <= 1'b1;
            buf_wdat_q <= mem_rdata;
            pix_q      <= pix_q + 1'b1;
            mem_addr_q <= mem_addr_q + 1'b1;
`ifdef PIXEL_DOUBLE_EN
            buf_addr_q <= {bank_q, pix_q[PIX_W-2:0], 1'b0};
            dbl_q      <= 1'b1;
            mem_req_q  <= 1'b0;
            if (enable && pix_q == LAST_FETCH) state_q <= ST_DRAIN;
`else
            buf_addr_q <= {bank_q, pix_q};
            if (!enable) begin
              // Abort: the acked pixel is still written, but no done.
              mem_req_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else if (pix_q == LAST_FETCH) begin
              mem_req_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_DRAIN;
            end
`endif
          end
        end

        ST_DRAIN: begin
`ifdef PIXEL_DOUBLE_EN
          if (dbl_q) begin
            buf_we_q      <= 1'b1;
            buf_addr_q[0] <= 1'b1;
            dbl_q         <= 1'b0;
            done_q        <= 1'b1;
          end else
`endif
          begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign buf_addr = buf_addr_q;
  assign buf_wdat = buf_wdat_q;
  assign buf_we   = buf_we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomised self-checking bench for vga_line_fetch against a line-level model.
module tb_vga_line_fetch;

  localparam int          H  = 640;
  localparam int          V  = 480;
  localparam logic [23:0] FB = 24'h001000;
`ifdef PIXEL_DOUBLE_EN
  localparam int NF  = H / 2;
  localparam int WPF = 2;
`else
  localparam int NF  = H;
  localparam int WPF = 1;
`endif

  logic        sys_clk = 1'b0;
  logic        rst, enable, line_start, mem_ack;
  logic [9:0]  line_num;
  logic [7:0]  mem_rdata;
  logic        mem_req, buf_we, busy, done, overrun;
  logic [23:0] mem_addr;
  logic [10:0] buf_addr;
  logic [7:0]  buf_wdat;

  vga_line_fetch #(
    .COLOR_DEPTH(8), .H_PIXELS(H), .V_LINES(V), .ADDR_W(24), .FB_BASE(FB)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .line_start(line_start),
    .line_num(line_num), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .buf_addr(buf_addr),
    .buf_wdat(buf_wdat), .buf_we(buf_we), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0, errors = 0, cyc = 0;
  int          ack_pct = 100;
  logic [7:0]  salt;
  logic [23:0] xfer_q[$];
  logic [10:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          done_cnt, done_idx, done_cyc, busy_fall;
  bit          busy_prev = 0, pend = 0;
  logic [23:0] pend_addr;

  function automatic logic [7:0] data_of(input logic [23:0] a);
    logic [23:0] t;
    t = a ^ {3{salt}};
    return t[7:0] ^ {t[12:8], t[15:13]} ^ t[23:16];
  endfunction

  function automatic logic [23:0] exp_xfer(input int line, input int i);
`ifdef PIXEL_DOUBLE_EN
    return FB + 24'((line / 2) * (H / 2) + i);
`else
    return FB + 24'(line * H + i);
`endif
  endfunction

  function automatic logic [10:0] exp_waddr(input int line, input int w);
    return 11'((line % 2) * 1024 + w);
  endfunction

  function automatic logic [7:0] exp_wdat(input int line, input int w);
    return data_of(exp_xfer(line, w / WPF));
  endfunction

  // One clock: sample outputs at negedge, then drive the memory response.
  task automatic step();
    @(negedge sys_clk);
    cyc++;
    if (buf_we) begin
      wa_q.push_back(buf_addr);
      wd_q.push_back(buf_wdat);
    end
    if (done) begin
      done_cnt++;
      done_idx = wa_q.size();
      done_cyc = cyc;
      checks++;
      if (buf_we !== 1'b1) begin
        errors++;
        $display("FAIL done_with_we: buf_we=%b required 1", buf_we);
      end
    end
    if (busy_prev && !busy && busy_fall < 0) busy_fall = cyc;
    busy_prev = busy;
    if (pend) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== pend_addr) begin
        errors++;
        $display("FAIL addr_hold: mem_req=%b mem_addr=%h required 1 %h",
                 mem_req, mem_addr, pend_addr);
      end
    end
    mem_ack   = (ack_pct >= 100) ? 1'b1 : ($urandom_range(99) < ack_pct);
    mem_rdata = data_of(mem_addr);
    if (mem_req && mem_ack) xfer_q.push_back(mem_addr);
    pend      = mem_req && !mem_ack;
    pend_addr = mem_addr;
  endtask

  task automatic clear_tracking();
    xfer_q.delete(); wa_q.delete(); wd_q.delete();
    done_cnt = 0; done_idx = -1; done_cyc = -1; busy_fall = -1;
  endtask

  task automatic start_line(input int line);
    clear_tracking();
    line_num = 10'(line); line_start = 1'b1;
    step();
    line_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: busy=%b mem_req=%b required 1 1", busy, mem_req);
    end
  endtask

  task automatic finish_line(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL line_timeout: busy=%b after %0d cycles required 0", busy, n);
    end
    repeat (3) step();
  endtask

  task automatic check_line(input int line, input bit exp_done);
    int nx, nw, n;
    nx = exp_done ? NF : xfer_q.size();
    nw = nx * WPF;
    if (exp_done) begin
      checks++;
      if (xfer_q.size() != nx) begin
        errors++;
        $display("FAIL xfer_count L%0d: got %0d required %0d", line, xfer_q.size(), nx);
      end
    end
    n = (xfer_q.size() < nx) ? xfer_q.size() : nx;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (xfer_q[i] !== exp_xfer(line, i)) begin
        errors++;
        $display("FAIL xfer_addr L%0d #%0d: got %h required %h", line, i, xfer_q[i], exp_xfer(line, i));
      end
    end
    checks++;
    if (wa_q.size() != nw) begin
      errors++;
      $display("FAIL write_count L%0d: got %0d required %0d", line, wa_q.size(), nw);
    end
    n = (wa_q.size() < nw) ? wa_q.size() : nw;
    for (int w = 0; w < n; w++) begin
      checks++;
      if (wa_q[w] !== exp_waddr(line, w) || wd_q[w] !== exp_wdat(line, w)) begin
        errors++;
        $display("FAIL write L%0d #%0d: got %h/%h required %h/%h", line, w,
                 wa_q[w], wd_q[w], exp_waddr(line, w), exp_wdat(line, w));
      end
    end
    checks++;
    if (done_cnt != (exp_done ? 1 : 0)) begin
      errors++;
      $display("FAIL done_count L%0d: got %0d required %0d", line, done_cnt, exp_done ? 1 : 0);
    end
    if (exp_done) begin
      checks++;
      if (done_idx != nw) begin
        errors++;
        $display("FAIL done_on_last L%0d: at write %0d required %0d", line, done_idx, nw);
      end
      checks++;
      if (busy_fall != done_cyc + 1) begin
        errors++;
        $display("FAIL busy_fall L%0d: cycle %0d required %0d", line, busy_fall, done_cyc + 1);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({mem_req, mem_addr, buf_addr, buf_wdat, buf_we, busy, done, overrun} !== '0) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h baddr=%h wdat=%h we=%b busy=%b done=%b ovr=%b required all 0",
               name, mem_req, mem_addr, buf_addr, buf_wdat, buf_we, busy, done, overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; line_start = 1'b0; line_num = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) step();
    check_all_zero("reset_state");
    rst = 1'b0; enable = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    ack_pct = 100;
    start_line(3); finish_line(3000); check_line(3, 1);
    start_line(5); finish_line(3000); check_line(5, 1);
  endtask

  task automatic test_wait_states();
    ack_pct = 50;
    start_line(0); finish_line(6000); check_line(0, 1);
  endtask

  task automatic test_random_lines();
    int l;
    repeat (3) begin
      l = $urandom_range(V - 1);
      ack_pct = $urandom_range(100, 30);
      start_line(l); finish_line(8000); check_line(l, 1);
    end
  endtask

  task automatic test_overrun();
    ack_pct = 100;
    start_line(1);
    repeat (100) step();
    line_num = 10'd2; line_start = 1'b1;
    step();
    line_start = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b required 1", overrun); end
    finish_line(3000);
    check_line(1, 1);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b required 1", overrun); end
    enable = 1'b0;
    step();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b required 0", overrun); end
    enable = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    ack_pct = 100;
    start_line(6);
    while (xfer_q.size() < NF && n < 3000) begin step(); n++; end
    line_num = 10'd8; line_start = 1'b1;
    step();
    line_start = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL last_xfer_overrun: got %b required 1", overrun); end
    finish_line(100);
    check_line(6, 1);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL last_xfer_ignored: busy=%b mem_req=%b required 0 0", busy, mem_req);
    end
    enable = 1'b0; step(); enable = 1'b1; step();
  endtask

  task automatic test_ignored();
    int  lines[3] = '{480, 1023, 5};
    bit  ens[3]   = '{1'b1, 1'b1, 1'b0};
    bit  bad;
    ack_pct = 100;
    for (int k = 0; k < 3; k++) begin
      clear_tracking();
      enable = ens[k]; line_num = 10'(lines[k]); line_start = 1'b1;
      bad = 0;
      step();
      line_start = 1'b0;
      repeat (20) begin
        if (mem_req || buf_we || busy) bad = 1;
        step();
      end
      checks++;
      if (bad || wa_q.size() != 0) begin
        errors++;
        $display("FAIL ignored_req line=%0d en=%0b: activity seen, writes=%0d required none",
                 lines[k], ens[k], wa_q.size());
      end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ignored_overrun line=%0d: got %b required 0", lines[k], overrun); end
    end
    enable = 1'b1;
    step();
  endtask

  task automatic test_abort();
    int n = 0;
    ack_pct = 100;
    start_line(7);
    repeat (50) step();
    ack_pct = 0;
    step();
    while (mem_req !== 1'b1 && n < 4) begin step(); n++; end
    enable = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_hold_req: got %b required 1", mem_req); end
    end
    ack_pct = 100;
    step();
    step();
    checks++;
    if (buf_we !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_final_write: buf_we=%b done=%b required 1 0", buf_we, done);
    end
    repeat (4) step();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b mem_req=%b required 0 0", busy, mem_req);
    end
    check_line(7, 0);
    enable = 1'b1;
    step();
    start_line(8); finish_line(3000); check_line(8, 1);
  endtask

  task automatic test_rst_mid();
    int n = 0;
    ack_pct = 100;
    start_line(9);
    while (wa_q.size() < 200 && n < 2000) begin step(); n++; end
    rst = 1'b1;
    step();
    check_all_zero("reset_mid_fetch");
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: busy=%b mem_req=%b required 0 0", busy, mem_req);
    end
  endtask

  initial begin
    salt = 8'($urandom);
    test_reset();
    test_nominal();
    test_wait_states();
    test_random_lines();
    test_overrun();
    test_back_to_back();
    test_ignored();
    test_abort();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
